audio_mem_arbiter: RTL and testbench

- Two-port Avalon-MM arbiter that shares the 2048x32 single-port on-chip RAM between two masters.
- Port 0 is the audio sample DMA writer; port 1 is the UART/CPU bridge.
- Round-robin grant, with an optional lock for read-modify-write sequences and a lock-hold timeout.
- Routes read data back to the issuing master using a latency-matched tag pipeline; sits directly in front of the RAM's s1 slave.

---
 rtl/audio_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_audio_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mem_arbiter.sv
// audio_mem_arbiter
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Port 0 is the audio sample DMA writer and port 1 is the UART/CPU bridge.
// A grant is decided combinationally each cycle using round-robin priority.
// An optional lock lets one port own the RAM for read-modify-write
// sequences, and the lock is broken if it is held for too long.
// Read data is broadcast to both masters, and a tag pipeline that matches
// the RAM read latency steers readdatavalid to the master that issued the
// read.
module audio_mem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int LOCK_MAX     = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic req0, req1;
  logic gnt0, gnt1;
  logic gnt_any, gnt_port, gnt_rd, gnt_lock;
  logic prio_ptr;              // 0: port 0 wins contention, 1: port 1 wins
  logic lock_vld;
  logic lock_own;
  logic [CNT_W-1:0] lock_cnt;
  logic timeout_hit, owner_rel;

  // Read-return tag pipeline: one {valid, port} pair per RAM latency stage
  logic [READ_LATENCY-1:0] vld_p;
  logic [READ_LATENCY-1:0] port_p;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant selection: the lock owner is exclusive, otherwise round-robin;
  // nothing is granted while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (lock_vld) begin
        gnt0 = req0 & ~lock_own;
        gnt1 = req1 & lock_own;
      end else if (req0 & req1) begin
        gnt0 = ~prio_ptr;
        gnt1 = prio_ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign gnt_port = gnt1;
  // Read+write together counts as a write, so a read needs write low
  assign gnt_rd   = (gnt0 & ~m0_write) | (gnt1 & ~m1_write);
  assign gnt_lock = (gnt0 & m0_lock) | (gnt1 & m1_lock);

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  // RAM drive: the granted port's fields, or all zero when idle
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (gnt0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
    end else if (gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
    end
  end

  assign mem_clken = 1'b1;

  // A release by the owner takes precedence over a timeout in the same cycle
  assign timeout_hit = lock_vld & (lock_cnt == CNT_W'(LOCK_MAX - 1));
  assign owner_rel   = lock_vld & gnt_any & ~gnt_lock;

  // Lock ownership, hold counter, timeout flag and priority pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_vld     <= 1'b0;
      lock_own     <= 1'b0;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
      prio_ptr     <= 1'b0;
    end else begin
      if (lock_vld) begin
        if (owner_rel) begin
          lock_vld <= 1'b0;
          lock_cnt <= '0;
        end else if (timeout_hit) begin
          lock_vld     <= 1'b0;
          lock_cnt     <= '0;
          lock_timeout <= 1'b1;
        end else begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else if (gnt_any & gnt_lock) begin
        lock_vld <= 1'b1;
        lock_own <= gnt_port;
        lock_cnt <= '0;
      end

      if (timeout_hit & ~owner_rel)
        prio_ptr <= ~lock_own;
      else if (gnt_any)
        prio_ptr <= ~gnt_port;
    end
  end

  // Stage p0 captures the granted read; later stages track RAM latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= gnt_rd;
      for (int i = 1; i < READ_LATENCY; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

  // The port tag is qualified by vld_p, so it needs no reset
  always_ff @(posedge clk) begin
    port_p[0] <= gnt_port;
    for (int i = 1; i < READ_LATENCY; i++)
      port_p[i] <= port_p[i-1];
  end

  // Output stage: steer the valid strobe and broadcast read data
  assign m0_readdatavalid = vld_p[READ_LATENCY-1] & ~port_p[READ_LATENCY-1];
  assign m1_readdatavalid = vld_p[READ_LATENCY-1] & port_p[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Directed bench for audio_mem_arbiter with a behavioural 2048x32 RAM
// (read latency 1). Inputs change 1 ns after each rising edge and outputs
// are checked 1 ns later.
module tb_audio_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] m0_address, m1_address;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, lock_timeout;
  logic [31:0] mem_writedata, mem_readdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:2047];

  always #5 clk = ~clk;

  audio_mem_arbiter #(
    .ADDR_W(11), .DATA_W(32), .BE_W(4), .READ_LATENCY(1), .LOCK_MAX(64)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .lock_timeout(lock_timeout)
  );

  // Single-port RAM model: byte-lane writes, registered read
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_drv(input logic rd, input logic wr, input logic lk,
                        input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_lock = lk;
    m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic m1_drv(input logic rd, input logic wr, input logic lk,
                        input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_lock = lk;
    m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic idle_all();
    m0_drv(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m1_drv(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    m0_read = 1'b1;
    next(); next();
    #1;
    chk1("rst_cs", mem_chipselect, 1'b0);
    chk1("rst_wr", mem_write, 1'b0);
    chk1("rst_rdv0", m0_readdatavalid, 1'b0);
    chk1("rst_rdv1", m1_readdatavalid, 1'b0);
    chk1("rst_clken", mem_clken, 1'b1);
    chk1("rst_lto", lock_timeout, 1'b0);
    reset_n = 1'b1;
    idle_all();
    next();

    // Write then read back through the other port
    m0_drv(1'b0, 1'b1, 1'b0, 11'h0A5, 4'hF, 32'hDEADBEEF);
    #1;
    chk1("w_wait0", m0_waitrequest, 1'b0);
    chk1("w_cs", mem_chipselect, 1'b1);
    chk1("w_wr", mem_write, 1'b1);
    chk32("w_addr", 32'(mem_address), 32'h0A5);
    chk32("w_data", mem_writedata, 32'hDEADBEEF);
    chk32("w_be", 32'(mem_byteenable), 32'hF);
    next();
    idle_all();
    m1_drv(1'b0, 1'b1, 1'b0, 11'h020, 4'hF, 32'h20202020);
    next();
    idle_all();
    m0_drv(1'b0, 1'b1, 1'b0, 11'h010, 4'hF, 32'h10101010);
    next();
    idle_all();
    m1_drv(1'b1, 1'b0, 1'b0, 11'h0A5, 4'hF, 32'h0);
    #1;
    chk1("r_wait1", m1_waitrequest, 1'b0);
    chk1("r_wr", mem_write, 1'b0);
    next();
    idle_all();
    #1;
    chk1("r_rdv1", m1_readdatavalid, 1'b1);
    chk32("r_data1", m1_readdata, 32'hDEADBEEF);
    chk1("r_rdv0", m0_readdatavalid, 1'b0);
    next();

    // Both ports reading: grants alternate m0, m1, m0
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    m1_drv(1'b1, 1'b0, 1'b0, 11'h020, 4'hF, 32'h0);
    #1;
    chk1("rr1_w0", m0_waitrequest, 1'b0);
    chk1("rr1_w1", m1_waitrequest, 1'b1);
    chk32("rr1_addr", 32'(mem_address), 32'h010);
    next();
    #1;
    chk1("rr2_w0", m0_waitrequest, 1'b1);
    chk1("rr2_w1", m1_waitrequest, 1'b0);
    chk32("rr2_addr", 32'(mem_address), 32'h020);
    chk1("rr2_rdv0", m0_readdatavalid, 1'b1);
    chk1("rr2_rdv1", m1_readdatavalid, 1'b0);
    chk32("rr2_data", m0_readdata, 32'h10101010);
    next();
    #1;
    chk1("rr3_w0", m0_waitrequest, 1'b0);
    chk1("rr3_w1", m1_waitrequest, 1'b1);
    chk1("rr3_rdv0", m0_readdatavalid, 1'b0);
    chk1("rr3_rdv1", m1_readdatavalid, 1'b1);
    chk32("rr3_data", m1_readdata, 32'h20202020);
    next();
    idle_all();
    #1;
    chk1("rr4_rdv0", m0_readdatavalid, 1'b1);
    chk1("rr4_rdv1", m1_readdatavalid, 1'b0);
    chk32("rr4_data", m0_readdata, 32'h10101010);
    next();

    // Partial write into 0x11223344 with byte lane 1
    m1_drv(1'b0, 1'b1, 1'b0, 11'h030, 4'hF, 32'h11223344);
    next();
    idle_all();
    m0_drv(1'b0, 1'b1, 1'b0, 11'h030, 4'h2, 32'h00003400);
    #1;
    chk32("pw_be", 32'(mem_byteenable), 32'h2);
    next();
    m0_drv(1'b1, 1'b0, 1'b0, 11'h030, 4'hF, 32'h0);
    next();
    idle_all();
    #1;
    chk1("pw_rdv0", m0_readdatavalid, 1'b1);
    chk32("pw_data", m0_readdata, 32'h11223444);
    next();

    // m1 locks and idles 10 cycles while m0 requests
    m1_drv(1'b0, 1'b1, 1'b1, 11'h040, 4'hF, 32'hCAFE0001);
    #1;
    chk1("lk_acq_w1", m1_waitrequest, 1'b0);
    next();
    m1_drv(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("lk_hold_w0", m0_waitrequest, 1'b1);
      chk1("lk_hold_cs", mem_chipselect, 1'b0);
      next();
    end
    m1_drv(1'b1, 1'b0, 1'b0, 11'h040, 4'hF, 32'h0);
    #1;
    chk1("lk_rel_w1", m1_waitrequest, 1'b0);
    chk1("lk_rel_w0", m0_waitrequest, 1'b1);
    next();
    m1_drv(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk1("lk_after_w0", m0_waitrequest, 1'b0);
    chk1("lk_after_rdv1", m1_readdatavalid, 1'b1);
    chk32("lk_after_data", m1_readdata, 32'hCAFE0001);
    next();
    idle_all();
    #1;
    chk1("lk_after_rdv0", m0_readdatavalid, 1'b1);
    next();

    // m0 locks and never releases: forced break after 64 held cycles
    m0_drv(1'b0, 1'b1, 1'b1, 11'h050, 4'hF, 32'h5);
    #1;
    chk1("to_acq_w0", m0_waitrequest, 1'b0);
    next();
    m0_drv(1'b0, 1'b0, 1'b1, 11'h0, 4'h0, 32'h0);
    m1_drv(1'b1, 1'b0, 1'b0, 11'h020, 4'hF, 32'h0);
    for (int i = 1; i <= 64; i++) begin
      #1;
      chk1("to_hold_w1", m1_waitrequest, 1'b1);
      chk1("to_hold_lto", lock_timeout, 1'b0);
      next();
    end
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    #1;
    chk1("to_brk_w1", m1_waitrequest, 1'b0);
    chk1("to_brk_w0", m0_waitrequest, 1'b1);
    chk1("to_brk_lto", lock_timeout, 1'b1);
    next();
    m1_drv(1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk1("to_next_w0", m0_waitrequest, 1'b0);
    chk1("to_next_rdv1", m1_readdatavalid, 1'b1);
    chk32("to_next_data", m1_readdata, 32'h20202020);
    chk1("to_sticky1", lock_timeout, 1'b1);
    next();
    idle_all();
    #1;
    chk1("to_sticky2", lock_timeout, 1'b1);
    chk1("to_rdv0", m0_readdatavalid, 1'b1);
    next();

    // Reset with a read in flight
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    next();
    reset_n = 1'b0;
    idle_all();
    #1;
    chk1("rif_rdv0", m0_readdatavalid, 1'b0);
    chk1("rif_rdv1", m1_readdatavalid, 1'b0);
    chk1("rif_lto", lock_timeout, 1'b0);
    chk1("rif_cs", mem_chipselect, 1'b0);
    next();
    chk1("rif_rdv0b", m0_readdatavalid, 1'b0);
    reset_n = 1'b1;
    next();
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    m1_drv(1'b1, 1'b0, 1'b0, 11'h020, 4'hF, 32'h0);
    #1;
    chk1("rif_ptr_w0", m0_waitrequest, 1'b0);
    chk1("rif_ptr_w1", m1_waitrequest, 1'b1);
    next();
    idle_all();
    next();

    // Timeout edge coinciding with the owner's release counts as release
    m0_drv(1'b1, 1'b0, 1'b1, 11'h010, 4'hF, 32'h0);
    #1;
    chk1("tr_acq_w0", m0_waitrequest, 1'b0);
    next();
    idle_all();
    for (int i = 1; i <= 63; i++) next();
    m0_drv(1'b1, 1'b0, 1'b0, 11'h010, 4'hF, 32'h0);
    #1;
    chk1("tr_rel_w0", m0_waitrequest, 1'b0);
    next();
    idle_all();
    m1_drv(1'b1, 1'b0, 1'b0, 11'h020, 4'hF, 32'h0);
    #1;
    chk1("tr_lto", lock_timeout, 1'b0);
    chk1("tr_free_w1", m1_waitrequest, 1'b0);
    next();
    idle_all();
    next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
